icache_lock_ctrl: RTL and testbench

Cache-side responder to the decode-stage loop detector. It consumes `lock_cache`/`lock_start` and maintains a per-set, per-way lock table for the I-cache. It serves a registered victim-protection mask to the replacement logic. When the locked working set no longer fits a set, it returns `lockflush` to the detector.

---
 rtl/icache_lock_ctrl.sv | 126 ++++++++++++
 tb/tb_icache_lock_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_lock_ctrl.sv
// I-cache way-lock table driven by the loop detector.
// Serves a registered victim-protection mask and flags saturated sets.
module icache_lock_ctrl #(
  parameter int SETS     = 64,
  parameter int WAYS     = 2,
  parameter int LOCK_MAX = WAYS - 1,
  parameter int IDX_W    = $clog2(SETS),
  parameter int WAY_W    = $clog2(WAYS),
  parameter int CNT_W    = $clog2(SETS * WAYS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_cache,
  input  logic             lock_start,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic             hit_valid,
  input  logic [IDX_W-1:0] hit_index,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             vict_rd,
  input  logic [IDX_W-1:0] vict_index,
  output logic [WAYS-1:0]  vict_mask,
  output logic             vict_mask_vld,
  output logic             lockflush,
  output logic             busy,
  output logic [CNT_W-1:0] locked_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ARMED
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sp;
  logic [WAYS-1:0]  r_table [SETS];
  logic [WAYS-1:0]  r_mask;
  logic             r_vld;
  logic             r_flush;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy;
  logic             w_req;
  logic [IDX_W-1:0] w_idx;
  logic [WAY_W-1:0] w_way;
  logic [WAYS-1:0]  w_row;
  logic [WAY_W:0]   w_pop;
  logic             w_room;
  logic             w_set;
  logic             w_rej;

  assign w_busy = (r_state == S_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (lock_start) w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (lock_start)
          w_state_nxt = S_CLEAR;
        else if (r_sp == IDX_W'(SETS - 1))
          w_state_nxt = S_ARMED;
      end
      S_ARMED: if (lock_start) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fill has priority over hit; the loser is silently dropped.
  always_comb begin
    w_req = (r_state == S_ARMED) && lock_cache && !lock_start &&
            (fill_valid || hit_valid);
    w_idx = fill_valid ? fill_index : hit_index;
    w_way = fill_valid ? fill_way : hit_way;
    w_row = r_table[w_idx];
    w_pop = '0;
    for (int i = 0; i < WAYS; i++)
      w_pop = w_pop + (WAY_W+1)'(w_row[i]);
    w_room = (w_pop < (WAY_W+1)'(LOCK_MAX));
    w_set  = w_req && !w_row[w_way] && w_room;
    w_rej  = w_req && !w_row[w_way] && !w_room;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sp    <= '0;
      r_mask  <= '0;
      r_vld   <= 1'b0;
      r_flush <= 1'b0;
      r_cnt   <= '0;
      for (int s = 0; s < SETS; s++)
        r_table[s] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_rej;
      if (lock_start) begin
        r_sp  <= '0;
        r_cnt <= '0;
      end else if (w_busy) begin
        r_table[r_sp] <= '0;
        r_sp          <= r_sp + IDX_W'(1);
      end else if (w_set) begin
        r_table[w_idx][w_way] <= 1'b1;
        r_cnt                 <= r_cnt + CNT_W'(1);
      end
      // Reads see the table before this cycle's update.
      if (vict_rd) begin
        r_mask <= w_busy ? '0 : r_table[vict_index];
        r_vld  <= 1'b1;
      end else begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign vict_mask     = r_mask;
  assign vict_mask_vld = r_vld;
  assign lockflush     = r_flush;
  assign busy          = w_busy;
  assign locked_count  = r_cnt;

endmodule

// File: tb/tb_icache_lock_ctrl.sv
// Bench for icache_lock_ctrl: cycle-indexed epoch model plus directed
// checks for release timing, saturation and priority rules.
module tb_icache_lock_ctrl;
  localparam int SETS = 64;
  localparam int WAYS = 2;
  localparam int LOCK_MAX = 1;
  localparam int IDX_W = 6;
  localparam int WAY_W = 1;
  localparam int CNT_W = 8;

  logic clk = 0;
  logic rst = 1;
  logic lock_cache = 0, lock_start = 0;
  logic fill_valid = 0, hit_valid = 0, vict_rd = 0;
  logic [IDX_W-1:0] fill_index = 0, hit_index = 0, vict_index = 0;
  logic [WAY_W-1:0] fill_way = 0, hit_way = 0;
  logic [WAYS-1:0] vict_mask;
  logic vict_mask_vld, lockflush, busy;
  logic [CNT_W-1:0] locked_count;

  int checks = 0;
  int failures = 0;

  icache_lock_ctrl #(.SETS(SETS), .WAYS(WAYS), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .lock_cache(lock_cache), .lock_start(lock_start),
    .fill_valid(fill_valid), .fill_index(fill_index),
    .fill_way(fill_way),
    .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
    .vict_rd(vict_rd), .vict_index(vict_index),
    .vict_mask(vict_mask), .vict_mask_vld(vict_mask_vld),
    .lockflush(lockflush), .busy(busy),
    .locked_count(locked_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t",
               n, act, exp, $time);
    end
  endtask

  // Model: epoch defined by the cycle of the last lock_start.
  int cy = 0;
  bit started = 0;
  int ls_t = 0;
  bit [WAYS-1:0] mtab [SETS];
  int mcnt = 0;
  logic [WAYS-1:0] e_mask = 0;
  bit e_vld = 0, e_flush = 0, e_busy = 0;
  bit mv = 0;

  always @(posedge clk) begin
    int c, idx, way;
    bit arm, bsy;
    c = cy;
    if (rst) begin
      started = 0;
      foreach (mtab[i]) mtab[i] = '0;
      mcnt = 0;
      e_mask = '0;
      e_vld = 0;
      e_flush = 0;
    end else begin
      arm = started && (c >= ls_t + SETS + 1);
      bsy = started && (c >= ls_t + 1) && (c <= ls_t + SETS);
      e_vld = vict_rd;
      if (vict_rd) e_mask = bsy ? '0 : mtab[vict_index];
      e_flush = 0;
      if (lock_start) begin
        started = 1;
        ls_t = c;
        mcnt = 0;
        foreach (mtab[i]) mtab[i] = '0;
      end else if (arm && lock_cache && (fill_valid || hit_valid)) begin
        idx = fill_valid ? int'(fill_index) : int'(hit_index);
        way = fill_valid ? int'(fill_way) : int'(hit_way);
        if (!mtab[idx][way]) begin
          if ($countones(mtab[idx]) < LOCK_MAX) begin
            mtab[idx][way] = 1'b1;
            mcnt++;
          end else begin
            e_flush = 1;
          end
        end
      end
    end
    cy = c + 1;
    e_busy = started && (cy >= ls_t + 1) && (cy <= ls_t + SETS);
    mv = 1;
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("m_mask", 32'(vict_mask), 32'(e_mask));
      chk("m_vld", 32'(vict_mask_vld), 32'(e_vld));
      chk("m_flush", 32'(lockflush), 32'(e_flush));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_cnt", 32'(locked_count), 32'(mcnt));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx);
    vict_rd = 1;
    vict_index = IDX_W'(idx);
    tick();
    vict_rd = 0;
  endtask

  task automatic fill(input int idx, input int way);
    fill_valid = 1;
    fill_index = IDX_W'(idx);
    fill_way = WAY_W'(way);
  endtask

  task automatic hit(input int idx, input int way);
    hit_valid = 1;
    hit_index = IDX_W'(idx);
    hit_way = WAY_W'(way);
  endtask

  initial begin
    tick(3);
    rst = 0;
    lock_cache = 1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(locked_count), 0);

    // IDLE ignores fills
    fill(5, 0);
    tick();
    fill_valid = 0;
    rd(5);
    chk("idle_mask", 32'(vict_mask), 0);
    chk("idle_vld", 32'(vict_mask_vld), 1);
    chk("idle_cnt", 32'(locked_count), 0);

    // release latency
    lock_start = 1;
    tick();
    lock_start = 0;
    chk("busy_t1", 32'(busy), 1);
    tick(63);
    chk("busy_t64", 32'(busy), 1);
    tick();
    chk("busy_t65", 32'(busy), 0);
    fill(5, 1);
    tick();
    fill_valid = 0;
    rd(5);
    chk("lock_mask", 32'(vict_mask), 2);
    chk("lock_cnt", 32'(locked_count), 1);

    // saturation reject, then redundant hit
    hit(5, 0);
    tick();
    hit_valid = 0;
    chk("rej_flush", 32'(lockflush), 1);
    chk("rej_cnt", 32'(locked_count), 1);
    tick();
    chk("rej_pulse_end", 32'(lockflush), 0);
    hit(5, 1);
    tick();
    hit_valid = 0;
    chk("dup_flush", 32'(lockflush), 0);
    chk("dup_cnt", 32'(locked_count), 1);
    hit(5, 0);
    tick();
    chk("b2b_flush1", 32'(lockflush), 1);
    tick();
    hit_valid = 0;
    chk("b2b_flush2", 32'(lockflush), 1);

    // fill beats hit
    fill(7, 0);
    hit(9, 1);
    tick();
    fill_valid = 0;
    hit_valid = 0;
    chk("prio_cnt", 32'(locked_count), 2);
    rd(9);
    chk("prio_m9", 32'(vict_mask), 0);
    rd(7);
    chk("prio_m7", 32'(vict_mask), 1);
    fill(7, 0);
    hit(5, 0);
    tick();
    fill_valid = 0;
    hit_valid = 0;
    chk("drop_noflush", 32'(lockflush), 0);

    // lock_start wins; concurrent read sees pre-clear data
    lock_start = 1;
    vict_rd = 1;
    vict_index = 5;
    fill(11, 0);
    tick();
    lock_start = 0;
    vict_rd = 0;
    chk("ls_rd_mask", 32'(vict_mask), 2);
    chk("ls_busy", 32'(busy), 1);
    chk("ls_cnt", 32'(locked_count), 0);
    fill(3, 0);
    tick();
    fill_valid = 0;
    chk("clr_noflush", 32'(lockflush), 0);
    tick(28);
    lock_start = 1;
    tick();
    lock_start = 0;
    tick(63);
    chk("rs_busy64", 32'(busy), 1);
    tick();
    chk("rs_busy65", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      int ix [4] = '{5, 7, 11, 3};
      rd(ix[k]);
      chk("post_clr_mask", 32'(vict_mask), 0);
    end

    // lock_cache=0 retains, blocks new locks
    fill(20, 0);
    tick();
    fill_valid = 0;
    chk("lc_cnt", 32'(locked_count), 1);
    lock_cache = 0;
    for (int k = 0; k < 10; k++) begin
      fill(30 + k, k % 2);
      tick();
    end
    fill_valid = 0;
    tick();
    chk("lc0_cnt", 32'(locked_count), 1);
    rd(30);
    chk("lc0_m30", 32'(vict_mask), 0);
    rd(20);
    chk("lc0_m20", 32'(vict_mask), 1);
    lock_cache = 1;

    // reset mid-sweep
    lock_start = 1;
    tick();
    lock_start = 0;
    vict_rd = 1;
    vict_index = 20;
    tick(5);
    vict_rd = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_vld", 32'(vict_mask_vld), 0);
    chk("mid_rst_mask", 32'(vict_mask), 0);
    chk("mid_rst_cnt", 32'(locked_count), 0);
    chk("mid_rst_flush", 32'(lockflush), 0);
    fill(40, 0);
    tick();
    fill_valid = 0;
    rd(40);
    chk("idle2_mask", 32'(vict_mask), 0);
    chk("idle2_cnt", 32'(locked_count), 0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
